// File: rtl/gamestate_pkg.sv
// gamestate_pkg: shared types and constants for the frogger game sequencer.
//   gs_state_t   - 3-bit sequencer state encoding
//   gs_sound_t   - 2-bit sound event code sent to the audio block
//   GS_SND_DEPTH - depth of the sound event FIFO
package gamestate_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        PLAYING   = 3'd1,
        DYING     = 3'd2,
        WIN       = 3'd3,
        GAME_OVER = 3'd4,
        PAUSED    = 3'd5
    } gs_state_t;

    typedef enum logic [1:0] {
        UI_PRESS    = 2'd0,
        NEXTLEVEL   = 2'd1,
        CRASH       = 2'd2,
        CELEBRATION = 2'd3
    } gs_sound_t;

    localparam int GS_SND_DEPTH = 2;

    // Counter width that never collapses to zero bits.
    function automatic int gs_width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gs_sound_fifo.sv
// gs_sound_fifo: show-ahead sound event FIFO, GS_SND_DEPTH entries.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   push, push_data  - enqueue request and its sound code
//   pop              - dequeue the head (ignored while empty)
//   full, empty      - occupancy flags
//   head             - current head entry (valid while !empty)
//   overflow         - sticky: a push was lost because the FIFO was full
module gs_sound_fifo
    import gamestate_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  gs_sound_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output gs_sound_t head,
    output logic      overflow
);

    localparam int PTR_W = gs_width_min1(GS_SND_DEPTH);
    localparam int CNT_W = $clog2(GS_SND_DEPTH + 1);

    gs_sound_t          mem [GS_SND_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_pop;
    logic               do_push;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(GS_SND_DEPTH));
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < GS_SND_DEPTH; i++) begin
                mem[i] <= UI_PRESS;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gamestate_ctrl.sv
// gamestate_ctrl: top-level game sequencer for the frogger core.
// Tracks game phase, level and lives, emits one-cycle win/lose pulses and
// queues sound events for the audio block.
// Optional feature macro: GAMESTATE_PAUSE_EN adds pause_btn and the PAUSED state.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   dpad_input[3:0]     - synchronised direction buttons (any rising press)
//   collision           - frog hit (level)
//   reached_end         - frog on goal row (level)
//   state[2:0]          - current gs_state_t
//   level, lives        - current level (0-based) and remaining lives
//   win_pulse           - one cycle per level clear
//   lose_pulse          - one cycle per life lost
//   sound_valid/sel     - head of the sound FIFO
//   sound_ready         - audio block accepts the head
//   sound_drop          - sticky FIFO overflow flag
//   pause_btn           - pause toggle (GAMESTATE_PAUSE_EN only)
//
// state     | meaning
// MENU      | idle, waiting for a press to start a game
// PLAYING   | game running, evaluating collision / goal
// DYING     | death animation, DEATH_CYCLES clocks, inputs ignored
// WIN       | last level cleared, press returns to MENU
// GAME_OVER | no lives left, press returns to MENU
// PAUSED    | play frozen, inputs ignored (GAMESTATE_PAUSE_EN only)
module gamestate_ctrl
    import gamestate_pkg::*;
#(
    parameter  int NUM_LEVELS   = 10,
    parameter  int NUM_LIVES    = 3,
    parameter  int DEATH_CYCLES = 32,
    localparam int LEVEL_W      = gs_width_min1(NUM_LEVELS),
    localparam int LIVES_W      = $clog2(NUM_LIVES + 1),
    localparam int DC_W         = $clog2(DEATH_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         dpad_input,
    input  logic               collision,
    input  logic               reached_end,
    output logic [2:0]         state,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic               win_pulse,
    output logic               lose_pulse,
    output logic               sound_valid,
    output logic [1:0]         sound_sel,
    input  logic               sound_ready,
    output logic               sound_drop
`ifdef GAMESTATE_PAUSE_EN
    ,
    input  logic               pause_btn
`endif
);

    localparam logic [2:0] ST_MENU      = MENU;
    localparam logic [2:0] ST_PLAYING   = PLAYING;
    localparam logic [2:0] ST_DYING     = DYING;
    localparam logic [2:0] ST_WIN       = WIN;
    localparam logic [2:0] ST_GAME_OVER = GAME_OVER;
`ifdef GAMESTATE_PAUSE_EN
    localparam logic [2:0] ST_PAUSED    = PAUSED;
`endif

    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);
    localparam logic [DC_W-1:0]    DC_INIT    = DC_W'(DEATH_CYCLES);

    logic [2:0]         state_q,  state_d;
    logic [LEVEL_W-1:0] level_q,  level_d;
    logic [LIVES_W-1:0] lives_q,  lives_d;
    logic [DC_W-1:0]    dc_q,     dc_d;
    logic               win_q,    win_d;
    logic               lose_q,   lose_d;
    logic               dpad_any_q;
    logic               press;
    logic               snd_push;
    gs_sound_t          snd_code;
    gs_sound_t          fifo_head;
    logic               fifo_full;
    logic               fifo_empty;

    assign press = (dpad_input != 4'd0) && !dpad_any_q;

`ifdef GAMESTATE_PAUSE_EN
    logic pause_q;
    logic pause_edge;
    assign pause_edge = pause_btn && !pause_q;
`endif

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        lives_d  = lives_q;
        dc_d     = dc_q;
        win_d    = 1'b0;
        lose_d   = 1'b0;
        snd_push = 1'b0;
        snd_code = UI_PRESS;
        case (state_q)
            ST_MENU: begin
                if (press) begin
                    state_d  = ST_PLAYING;
                    level_d  = '0;
                    lives_d  = LIVES_INIT;
                    snd_push = 1'b1;
                    snd_code = UI_PRESS;
                end
            end
            ST_PLAYING: begin
                if (collision) begin
                    lose_d   = 1'b1;
                    lives_d  = lives_q - LIVES_W'(1);
                    snd_push = 1'b1;
                    snd_code = CRASH;
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_DYING;
                        dc_d    = DC_INIT;
                    end
                end else if (reached_end) begin
                    win_d    = 1'b1;
                    snd_push = 1'b1;
                    if (level_q == LAST_LEVEL) begin
                        state_d  = ST_WIN;
                        snd_code = CELEBRATION;
                    end else begin
                        level_d  = level_q + LEVEL_W'(1);
                        snd_code = NEXTLEVEL;
                    end
                end
`ifdef GAMESTATE_PAUSE_EN
                else if (pause_edge) begin
                    state_d = ST_PAUSED;
                end
`endif
            end
            ST_DYING: begin
                // Exit on the cycle the counter reads 1 so DYING spans exactly DEATH_CYCLES clocks.
                if (dc_q <= DC_W'(1)) begin
                    state_d = ST_PLAYING;
                    dc_d    = '0;
                end else begin
                    dc_d = dc_q - DC_W'(1);
                end
            end
            ST_WIN, ST_GAME_OVER: begin
                if (press) begin
                    state_d  = ST_MENU;
                    snd_push = 1'b1;
                    snd_code = UI_PRESS;
                end
            end
`ifdef GAMESTATE_PAUSE_EN
            ST_PAUSED: begin
                if (pause_edge) begin
                    state_d = ST_PLAYING;
                end
            end
`endif
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_MENU;
            level_q    <= '0;
            lives_q    <= '0;
            dc_q       <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            dpad_any_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            lives_q    <= lives_d;
            dc_q       <= dc_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            dpad_any_q <= (dpad_input != 4'd0);
        end
    end

`ifdef GAMESTATE_PAUSE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_btn;
        end
    end
`endif

    gs_sound_fifo u_sound_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (snd_push),
        .push_data (snd_code),
        .pop       (sound_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .overflow  (sound_drop)
    );

    assign state       = state_q;
    assign level       = level_q;
    assign lives       = lives_q;
    assign win_pulse   = win_q;
    assign lose_pulse  = lose_q;
    assign sound_valid = !fifo_empty;
    assign sound_sel   = fifo_head;

endmodule

// File: tb/tb_gamestate_ctrl.sv
module tb_gamestate_ctrl;
    import gamestate_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] dpad_input;
    logic       collision;
    logic       reached_end;
    logic [2:0] state;
    logic [3:0] level;
    logic [1:0] lives;
    logic       win_pulse;
    logic       lose_pulse;
    logic       sound_valid;
    logic [1:0] sound_sel;
    logic       sound_ready;
    logic       sound_drop;
`ifdef GAMESTATE_PAUSE_EN
    logic       pause_btn;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    gamestate_ctrl #(
        .NUM_LEVELS   (10),
        .NUM_LIVES    (3),
        .DEATH_CYCLES (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dpad_input  (dpad_input),
        .collision   (collision),
        .reached_end (reached_end),
        .state       (state),
        .level       (level),
        .lives       (lives),
        .win_pulse   (win_pulse),
        .lose_pulse  (lose_pulse),
        .sound_valid (sound_valid),
        .sound_sel   (sound_sel),
        .sound_ready (sound_ready),
        .sound_drop  (sound_drop)
`ifdef GAMESTATE_PAUSE_EN
        ,
        .pause_btn   (pause_btn)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press-and-release; the press pushes UI_PRESS.
    task automatic press_to(input int exp_state);
        dpad_input = 4'b0100;
        exp_q.push_back(int'(UI_PRESS));
        step();
        chk("press_state", state, exp_state);
        dpad_input = 4'b0000;
        step();
    endtask

    task automatic hit(input int exp_lives, input int exp_state);
        collision = 1'b1;
        exp_q.push_back(int'(CRASH));
        step();
        collision = 1'b0;
        chk("hit_lose_pulse", lose_pulse, 1);
        chk("hit_lives", lives, exp_lives);
        chk("hit_state", state, exp_state);
    endtask

    task automatic dying_wait(input int start, output int n);
        int guard;
        n = start;
        guard = 0;
        while (state == 3'd2 && guard < 100) begin
            step();
            guard++;
            if (state == 3'd2) n++;
        end
        chk("dying_len", n, 32);
        chk("dying_exit_state", state, 1);
    endtask

    // Scoreboard monitor: compares every accepted sound event against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && sound_valid && sound_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sound_unexpected: got %0d expected none", sound_sel);
                end else begin
                    chk("sound_sel", sound_sel, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        reset_n     = 1'b0;
        dpad_input  = 4'b0000;
        collision   = 1'b0;
        reached_end = 1'b0;
        sound_ready = 1'b1;
`ifdef GAMESTATE_PAUSE_EN
        pause_btn   = 1'b0;
`endif
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_level", level, 0);
        chk("rst_lives", lives, 0);
        chk("rst_win", win_pulse, 0);
        chk("rst_lose", lose_pulse, 0);
        chk("rst_valid", sound_valid, 0);
        chk("rst_sel", sound_sel, 0);
        chk("rst_drop", sound_drop, 0);
        reset_n = 1'b1;
        step();

        // Start: press and hold; only one UI_PRESS expected.
        dpad_input = 4'b0001;
        exp_q.push_back(int'(UI_PRESS));
        step();
        chk("start_state", state, 1);
        chk("start_level", level, 0);
        chk("start_lives", lives, 3);
        chk("start_valid", sound_valid, 1);
        chk("start_sel", sound_sel, int'(UI_PRESS));
        repeat (4) step();
        chk("hold_state", state, 1);
        dpad_input = 4'b0000;
        step();

        // Collision and goal together: collision wins; inputs ignored in DYING.
        collision   = 1'b1;
        reached_end = 1'b1;
        exp_q.push_back(int'(CRASH));
        step();
        chk("both_lose", lose_pulse, 1);
        chk("both_win", win_pulse, 0);
        chk("both_state", state, 2);
        chk("both_lives", lives, 2);
        chk("both_level", level, 0);
        n = 1;
        repeat (10) begin
            step();
            if (state == 3'd2) n++;
        end
        chk("dying_lose_clear", lose_pulse, 0);
        chk("dying_lives_hold", lives, 2);
        chk("dying_level_hold", level, 0);
        collision   = 1'b0;
        reached_end = 1'b0;
        dying_wait(n, n);

        // Ten level clears to WIN.
        for (int i = 0; i < 10; i++) begin
            reached_end = 1'b1;
            exp_q.push_back((i == 9) ? int'(CELEBRATION) : int'(NEXTLEVEL));
            step();
            chk("lvl_win_pulse", win_pulse, 1);
            chk("lvl_lose_pulse", lose_pulse, 0);
            chk("lvl_level", level, (i == 9) ? 9 : i + 1);
            reached_end = 1'b0;
            step();
            chk("lvl_win_clear", win_pulse, 0);
        end
        chk("win_state", state, 3);
        press_to(0);
        chk("menu_level_hold", level, 9);
        chk("menu_lives_hold", lives, 2);

        // Second game: three hits to GAME_OVER.
        press_to(1);
        chk("g2_level", level, 0);
        chk("g2_lives", lives, 3);
        hit(2, 2);
        dying_wait(1, n);
        hit(1, 2);
        dying_wait(1, n);
        hit(0, 4);
        step();
        chk("go_lose_clear", lose_pulse, 0);
        chk("go_state_hold", state, 4);
        press_to(0);
        chk("go_menu_lives", lives, 0);

        // FIFO: three events with ready low; third is dropped.
        sound_ready = 1'b0;
        press_to(1);
        reached_end = 1'b1;
        exp_q.push_back(int'(NEXTLEVEL));
        step();
        reached_end = 1'b0;
        chk("fifo_drop_early", sound_drop, 0);
        step();
        reached_end = 1'b1;
        step();
        reached_end = 1'b0;
        chk("fifo_level", level, 2);
        chk("fifo_drop", sound_drop, 1);
        repeat (3) step();
        chk("fifo_hold_valid", sound_valid, 1);
        chk("fifo_hold_sel", sound_sel, int'(UI_PRESS));
        sound_ready = 1'b1;
        step();
        chk("drain1_valid", sound_valid, 1);
        chk("drain1_sel", sound_sel, int'(NEXTLEVEL));
        step();
        chk("drain2_valid", sound_valid, 0);
        chk("drop_sticky", sound_drop, 1);
        step();

`ifdef GAMESTATE_PAUSE_EN
        pause_btn = 1'b1;
        step();
        chk("pause_state", state, 5);
        pause_btn = 1'b0;
        step();
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("pause_coll_state", state, 5);
        chk("pause_coll_lives", lives, 3);
        chk("pause_coll_lose", lose_pulse, 0);
        reached_end = 1'b1;
        step();
        reached_end = 1'b0;
        chk("pause_goal_level", level, 2);
        pause_btn = 1'b1;
        step();
        chk("resume_state", state, 1);
        pause_btn = 1'b0;
        step();
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        chk("repause_state", state, 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_lives", lives, 0);
        chk("async_rst_level", level, 0);
        step();
        reset_n = 1'b1;
        step();
`endif

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
